mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning); one clock, reset synchronous and active-low:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- input_write_reg / input_write_data / input_inst / input_addr  in  5/32/32/32  EX/MEM fields
- input_mem_acess_addr / input_mem_write_data  in  32/32  EX/MEM fields
- input_exr_valid / input_exr_type / input_exr_a0  in  1/6/32  EX/MEM fields
- stall  in  5  pipeline stall vector; flush  in  1  exception flush
- output_write_reg / output_write_data / output_inst / output_addr  out  5/32/32/32  to MEM/WB
- output_exr_valid / output_exr_type / output_exr_a0  out  1/6/32  to MEM/WB
- stall_req  out  1  MEM stall request
- data_req / data_wr / data_size / data_addr / data_wdata  out  1/1/2/32/32  SRAM-like data port
- data_addr_ok / data_data_ok / data_rdata  in  1/1/32  SRAM-like data port

Function
REQ-002 SHALL decode input_inst[31:26] as: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; every other opcode is a non-memory instruction.
REQ-003 SHALL raise misalignment on: LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0.
REQ-004 SHALL set output_exr_valid=1, output_exr_type=AdEL (loads) or AdES (stores), and output_exr_a0=input_mem_acess_addr on misalignment when input_exr_valid=0.
REQ-005 SHALL pass input_exr_* through unchanged when input_exr_valid=1; no access is issued.
REQ-006 SHALL issue no access for non-memory instructions; all fields pass through combinationally; stall_req=0.
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT, DONE, DRAIN.
REQ-008 IDLE->REQ on a valid, aligned, exception-free memory instruction with flush=0; stall_req=1 from that cycle.
REQ-009 In REQ: data_req=1 held stable; REQ->WAIT on data_addr_ok=1.
REQ-010 In WAIT: WAIT->DONE on data_data_ok=1, data_rdata captured into a 32-bit load buffer.
REQ-011 data_data_ok outside WAIT/DRAIN SHALL be ignored.
REQ-012 In DONE: stall_req=0 and output_write_data=extended load buffer (stores: input_write_data).
REQ-013 DONE->IDLE when stall[3]=0; DONE holds while stall[3]=1.
REQ-014 flush in REQ before addr_ok: ->IDLE, request withdrawn.
REQ-015 flush in REQ with addr_ok the same cycle, or flush in WAIT without data_ok: ->DRAIN.
REQ-016 DRAIN SHALL wait for data_data_ok, discard data, then ->IDLE.
REQ-017 stall_req SHALL be 1 in DRAIN.
REQ-018 flush in WAIT with data_ok the same cycle: ->IDLE, data discarded.
REQ-019 flush in DONE: ->IDLE.
REQ-020 data_size SHALL be 0/1/2 for byte/half/word.
REQ-021 data_addr SHALL equal input_mem_acess_addr.
REQ-022 data_wdata SHALL replicate the byte (SB) or half (SH) across all lanes.
REQ-023 data_wr SHALL be 1 for stores.
REQ-024 Load extraction SHALL select the byte or half by addr[1:0], sign-extending LB/LH and zero-extending LBU/LHU.
REQ-025 Access latency SHALL be at least 2 cycles from entering REQ to DONE; zero-wait-state acknowledgements still pass through WAIT.

Reset
REQ-026 On clock edge with resetn=0: FSM->IDLE, load buffer=0, any pending transaction abandoned.
REQ-027 While resetn=0, all outputs SHALL be 0, including data_req, stall_req and output_exr_valid.

Structure
REQ-028 Shared package SHALL hold the opcode constants, ExcCode constants (AdEL=6'h04, AdES=6'h05), the data_size encodings and the FSM state encoding.
REQ-029 One sub-module, mem_load_align (combinational load extraction/extension), is natural; the FSM and store lane replication stay in mem_access.

Verification
REQ-030 LW addr 0x1000, addr_ok at cycle 1, data_ok at cycle 3, rdata 0xDEADBEEF -> stall_req high for cycles 0-3; output_write_data=0xDEADBEEF in DONE.
REQ-031 LB addr 0x1003, rdata 0x80FF1234 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x1002 -> 0x000080FF.
REQ-032 SH addr 0x2002, write_data 0x0000ABCD -> data_wdata=0xABCDABCD, data_size=1, data_wr=1.
REQ-033 SW addr 0x2001 -> data_req never asserted; output_exr_type=0x05; output_exr_a0=0x2001.
REQ-034 LW with flush in WAIT, data_ok 2 cycles later -> DRAIN, data discarded; the next LW completes with its own data.
REQ-035 resetn low during WAIT -> next cycle IDLE, data_req=0, stall_req=0; a later data_ok is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants for the MEM pipeline stage.
// Holds the load/store opcodes, the address-error exception codes,
// the data_size encodings and the access FSM state type.
package mem_access_pkg;

    // Memory opcodes (inst[31:26])
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // ExcCode values for address errors
    localparam logic [5:0] EXC_ADEL = 6'h04;
    localparam logic [5:0] EXC_ADES = 6'h05;

    // data_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_load_align: combinational load-data extraction.
// Selects the byte or halfword addressed by offset out of a 32-bit word
// and sign- or zero-extends it according to the load opcode.
// Ports:
//   op     in  6   load opcode (inst[31:26])
//   offset in  2   byte offset within the word (addr[1:0])
//   word   in  32  raw word returned by memory
//   data   out 32  extended load result
import mem_access_pkg::*;

module mem_load_align (
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[7:0];
        case (offset)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        sel_half = offset[1] ? word[31:16] : word[15:0];

        case (op)
            OP_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  data = {24'h000000, sel_byte};
            OP_LH:   data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  data = {16'h0000, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with an SRAM-like data port.
// Decodes load/store instructions, raises AdEL/AdES on misalignment,
// issues one data transaction per memory instruction and stalls the
// pipeline until the result is available. Flushes abandon the access;
// a transaction already accepted by memory is drained before idling.
// Ports:
//   clock, resetn                     clock / synchronous active-low reset
//   input_write_reg/_data/_inst/_addr EX/MEM destination, data, inst, PC
//   input_mem_acess_addr              effective memory address
//   input_mem_write_data              EX/MEM store field (unused here; stores
//                                     take their data from input_write_data)
//   input_exr_valid/_type/_a0         incoming exception state
//   stall, flush                      pipeline stall vector / exception flush
//   output_*                          to MEM/WB
//   stall_req                         MEM stage stall request
//   data_req/_wr/_size/_addr/_wdata   data port request side
//   data_addr_ok/_data_ok/_rdata      data port response side
import mem_access_pkg::*;

module mem_access (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  input_write_reg,
    input  logic [31:0] input_write_data,
    input  logic [31:0] input_inst,
    input  logic [31:0] input_addr,
    input  logic [31:0] input_mem_acess_addr,
    input  logic [31:0] input_mem_write_data,
    input  logic        input_exr_valid,
    input  logic [5:0]  input_exr_type,
    input  logic [31:0] input_exr_a0,
    input  logic [4:0]  stall,
    input  logic        flush,
    output logic [4:0]  output_write_reg,
    output logic [31:0] output_write_data,
    output logic [31:0] output_inst,
    output logic [31:0] output_addr,
    output logic        output_exr_valid,
    output logic [5:0]  output_exr_type,
    output logic [31:0] output_exr_a0,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_t      state;
    state_t      state_next;
    logic [31:0] load_buf;
    logic [31:0] load_ext;

    logic [5:0]  opcode;
    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic        start;
    logic [1:0]  size;
    logic [31:0] wdata_rep;

    // Only stall[3] (MEM/WB hold) matters to this stage.
    logic        unused_inputs;
    assign unused_inputs = &{1'b0, stall[4], stall[2:0], input_mem_write_data};

    // ---------------- decode ----------------
    always_comb begin
        opcode   = input_inst[31:26];
        is_load  = is_load_op(opcode);
        is_store = is_store_op(opcode);

        misalign = 1'b0;
        if ((opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH))
            misalign = input_mem_acess_addr[0];
        else if ((opcode == OP_LW) || (opcode == OP_SW))
            misalign = (input_mem_acess_addr[1:0] != 2'b00);

        start = (is_load || is_store) && !misalign && !input_exr_valid && !flush;

        case (opcode)
            OP_LB, OP_LBU, OP_SB: size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: size = SIZE_HALF;
            default:              size = SIZE_WORD;
        endcase

        case (opcode)
            OP_SB:   wdata_rep = {4{input_write_data[7:0]}};
            OP_SH:   wdata_rep = {2{input_write_data[15:0]}};
            default: wdata_rep = input_write_data;
        endcase
    end

    mem_load_align u_load_align (
        .op     (opcode),
        .offset (input_mem_acess_addr[1:0]),
        .word   (load_buf),
        .data   (load_ext)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            load_buf <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_WAIT) && data_data_ok && !flush)
                load_buf <= data_rdata;
        end
    end

    // ---------------- next state ----------------
    // Data arriving in REQ is ignored, so even a zero-wait memory
    // passes through WAIT before DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_REQ;
            end
            ST_REQ: begin
                if (flush)
                    state_next = data_addr_ok ? ST_DRAIN : ST_IDLE;
                else if (data_addr_ok)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)
                    state_next = data_data_ok ? ST_IDLE : ST_DRAIN;
                else if (data_data_ok)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                if (flush || !stall[3])
                    state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        output_write_reg  = '0;
        output_write_data = '0;
        output_inst       = '0;
        output_addr       = '0;
        output_exr_valid  = 1'b0;
        output_exr_type   = '0;
        output_exr_a0     = '0;
        stall_req         = 1'b0;
        data_req          = 1'b0;
        data_wr           = 1'b0;
        data_size         = '0;
        data_addr         = '0;
        data_wdata        = '0;

        if (resetn) begin
            output_write_reg  = input_write_reg;
            output_inst       = input_inst;
            output_addr       = input_addr;
            output_write_data = ((state == ST_DONE) && is_load) ? load_ext : input_write_data;

            // An upstream exception always wins over a local address error.
            if (input_exr_valid) begin
                output_exr_valid = 1'b1;
                output_exr_type  = input_exr_type;
                output_exr_a0    = input_exr_a0;
            end else if (misalign) begin
                output_exr_valid = 1'b1;
                output_exr_type  = is_store ? EXC_ADES : EXC_ADEL;
                output_exr_a0    = input_mem_acess_addr;
            end else begin
                output_exr_valid = 1'b0;
                output_exr_type  = input_exr_type;
                output_exr_a0    = input_exr_a0;
            end

            case (state)
                ST_IDLE:                   stall_req = start;
                ST_REQ, ST_WAIT, ST_DRAIN: stall_req = 1'b1;
                default:                   stall_req = 1'b0;
            endcase

            data_req   = (state == ST_REQ);
            data_wr    = is_store;
            data_size  = size;
            data_addr  = input_mem_acess_addr;
            data_wdata = wdata_rep;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access.
import mem_access_pkg::*;

module tb_mem_access;

    logic        clock;
    logic        resetn;
    logic [4:0]  input_write_reg;
    logic [31:0] input_write_data;
    logic [31:0] input_inst;
    logic [31:0] input_addr;
    logic [31:0] input_mem_acess_addr;
    logic [31:0] input_mem_write_data;
    logic        input_exr_valid;
    logic [5:0]  input_exr_type;
    logic [31:0] input_exr_a0;
    logic [4:0]  stall;
    logic        flush;
    logic [4:0]  output_write_reg;
    logic [31:0] output_write_data;
    logic [31:0] output_inst;
    logic [31:0] output_addr;
    logic        output_exr_valid;
    logic [5:0]  output_exr_type;
    logic [31:0] output_exr_a0;
    logic        stall_req;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mem_access dut (
        .clock                (clock),
        .resetn               (resetn),
        .input_write_reg      (input_write_reg),
        .input_write_data     (input_write_data),
        .input_inst           (input_inst),
        .input_addr           (input_addr),
        .input_mem_acess_addr (input_mem_acess_addr),
        .input_mem_write_data (input_mem_write_data),
        .input_exr_valid      (input_exr_valid),
        .input_exr_type       (input_exr_type),
        .input_exr_a0         (input_exr_a0),
        .stall                (stall),
        .flush                (flush),
        .output_write_reg     (output_write_reg),
        .output_write_data    (output_write_data),
        .output_inst          (output_inst),
        .output_addr          (output_addr),
        .output_exr_valid     (output_exr_valid),
        .output_exr_type      (output_exr_type),
        .output_exr_a0        (output_exr_a0),
        .stall_req            (stall_req),
        .data_req             (data_req),
        .data_wr              (data_wr),
        .data_size            (data_size),
        .data_addr            (data_addr),
        .data_wdata           (data_wdata),
        .data_addr_ok         (data_addr_ok),
        .data_data_ok         (data_data_ok),
        .data_rdata           (data_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
        input_inst           = {op, 26'h0000ABC};
        input_mem_acess_addr = addr;
        input_write_data     = wd;
        input_exr_valid      = 1'b0;
    endtask

    // Full access: IDLE -> REQ (addr_ok) -> WAIT (data_ok) -> DONE -> IDLE
    task automatic do_access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input logic [31:0] exp_wdata, input logic [1:0] exp_size,
                             input logic exp_wr, input logic [31:0] exp_result);
        set_op(op, addr, wd);
        #1;
        chk({tag, " idle stall_req"}, 32'(stall_req), 32'd1);
        tick();                                   // REQ
        chk({tag, " data_req"}, 32'(data_req), 32'd1);
        chk({tag, " data_addr"}, data_addr, addr);
        chk({tag, " data_size"}, 32'(data_size), 32'(exp_size));
        chk({tag, " data_wr"}, 32'(data_wr), 32'(exp_wr));
        chk({tag, " data_wdata"}, data_wdata, exp_wdata);
        data_addr_ok = 1'b1;
        tick();                                   // WAIT
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();                                   // DONE
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        chk({tag, " result"}, output_write_data, exp_result);
        chk({tag, " done stall_req"}, 32'(stall_req), 32'd0);
        chk({tag, " exr_valid"}, 32'(output_exr_valid), 32'd0);
        set_op(6'h00, 32'h0, 32'h0);
        tick();                                   // IDLE
    endtask

    task automatic chk_misalign(input string tag, input logic [5:0] op, input logic [31:0] addr,
                                input logic [5:0] exp_type);
        set_op(op, addr, 32'h0);
        #1;
        chk({tag, " exr_valid"}, 32'(output_exr_valid), 32'd1);
        chk({tag, " exr_type"}, 32'(output_exr_type), 32'(exp_type));
        chk({tag, " exr_a0"}, output_exr_a0, addr);
        chk({tag, " stall_req"}, 32'(stall_req), 32'd0);
        tick();
        chk({tag, " no data_req"}, 32'(data_req), 32'd0);
        set_op(6'h00, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        resetn               = 1'b0;
        input_write_reg      = 5'd7;
        input_write_data     = 32'hCAFEF00D;
        input_inst           = {OP_LW, 26'h0};
        input_addr           = 32'hBFC0_0100;
        input_mem_acess_addr = 32'h1000;
        input_mem_write_data = 32'h0;
        input_exr_valid      = 1'b1;
        input_exr_type       = 6'h0C;
        input_exr_a0         = 32'h55;
        stall                = 5'b0;
        flush                = 1'b0;
        data_addr_ok         = 1'b0;
        data_data_ok         = 1'b0;
        data_rdata           = 32'h0;

        // Reset: every output forced to zero
        tick();
        tick();
        chk("rst data_req", 32'(data_req), 32'd0);
        chk("rst stall_req", 32'(stall_req), 32'd0);
        chk("rst exr_valid", 32'(output_exr_valid), 32'd0);
        chk("rst write_data", output_write_data, 32'd0);
        chk("rst write_reg", 32'(output_write_reg), 32'd0);
        chk("rst data_addr", data_addr, 32'd0);

        // Non-memory passthrough
        resetn = 1'b1;
        set_op(6'h00, 32'h0, 32'h12345678);
        #1;
        chk("nop write_data", output_write_data, 32'h12345678);
        chk("nop write_reg", 32'(output_write_reg), 32'd7);
        chk("nop inst", output_inst, {6'h00, 26'h0000ABC});
        chk("nop stall_req", 32'(stall_req), 32'd0);
        tick();
        chk("nop data_req", 32'(data_req), 32'd0);

        // LW 0x1000, addr_ok cycle 1, data_ok cycle 3, DONE held by stall[3]
        set_op(OP_LW, 32'h1000, 32'h0);
        #1;
        chk("lw c0 stall_req", 32'(stall_req), 32'd1);
        chk("lw c0 data_req", 32'(data_req), 32'd0);
        tick();
        chk("lw c1 data_req", 32'(data_req), 32'd1);
        chk("lw c1 stall_req", 32'(stall_req), 32'd1);
        chk("lw c1 data_size", 32'(data_size), 32'd2);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("lw c2 data_req", 32'(data_req), 32'd0);
        chk("lw c2 stall_req", 32'(stall_req), 32'd1);
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEADBEEF;
        stall        = 5'b01000;
        #1;
        chk("lw c3 stall_req", 32'(stall_req), 32'd1);
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        chk("lw done stall_req", 32'(stall_req), 32'd0);
        chk("lw done data", output_write_data, 32'hDEADBEEF);
        tick();
        chk("lw hold data", output_write_data, 32'hDEADBEEF);
        stall = 5'b0;
        set_op(6'h00, 32'h0, 32'h77);
        tick();
        chk("lw after write_data", output_write_data, 32'h77);
        chk("lw after stall_req", 32'(stall_req), 32'd0);

        // Load extraction
        do_access("lb3",  OP_LB,  32'h1003, 32'h0, 32'h80FF1234, 32'h0, SIZE_BYTE, 1'b0, 32'hFFFFFF80);
        do_access("lbu3", OP_LBU, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, SIZE_BYTE, 1'b0, 32'h00000080);
        do_access("lhu2", OP_LHU, 32'h1002, 32'h0, 32'h80FF1234, 32'h0, SIZE_HALF, 1'b0, 32'h000080FF);
        do_access("lh2",  OP_LH,  32'h1002, 32'h0, 32'h80FF1234, 32'h0, SIZE_HALF, 1'b0, 32'hFFFF80FF);
        do_access("lh0",  OP_LH,  32'h1000, 32'h0, 32'h80FF1234, 32'h0, SIZE_HALF, 1'b0, 32'h00001234);
        do_access("lb1",  OP_LB,  32'h1001, 32'h0, 32'h80FF1234, 32'h0, SIZE_BYTE, 1'b0, 32'h00000012);

        // Stores: lane replication, result is input_write_data
        do_access("sh2", OP_SH, 32'h2002, 32'h0000ABCD, 32'hFFFFFFFF, 32'hABCDABCD, SIZE_HALF, 1'b1, 32'h0000ABCD);
        do_access("sb3", OP_SB, 32'h2003, 32'h123456EF, 32'hFFFFFFFF, 32'hEFEFEFEF, SIZE_BYTE, 1'b1, 32'h123456EF);
        do_access("sw4", OP_SW, 32'h2004, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h89ABCDEF, SIZE_WORD, 1'b1, 32'h89ABCDEF);

        // Misalignment
        chk_misalign("sw 2001",  OP_SW,  32'h2001, EXC_ADES);
        chk_misalign("lh 1001",  OP_LH,  32'h1001, EXC_ADEL);
        chk_misalign("lw 1002",  OP_LW,  32'h1002, EXC_ADEL);
        chk_misalign("sh 2003",  OP_SH,  32'h2003, EXC_ADES);
        chk_misalign("lhu 1003", OP_LHU, 32'h1003, EXC_ADEL);

        // Incoming exception passes through, even over misalignment
        set_op(OP_SW, 32'h2001, 32'h0);
        input_exr_valid = 1'b1;
        input_exr_type  = 6'h0A;
        input_exr_a0    = 32'h55;
        #1;
        chk("exr pass valid", 32'(output_exr_valid), 32'd1);
        chk("exr pass type", 32'(output_exr_type), 32'h0A);
        chk("exr pass a0", output_exr_a0, 32'h55);
        chk("exr pass stall_req", 32'(stall_req), 32'd0);
        tick();
        chk("exr pass data_req", 32'(data_req), 32'd0);
        set_op(6'h00, 32'h0, 32'h0);

        // Flush in REQ before addr_ok: request withdrawn
        set_op(OP_LW, 32'h3000, 32'h0);
        tick();
        chk("flreq data_req", 32'(data_req), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_op(6'h00, 32'h0, 32'h0);
        #1;
        chk("flreq idle data_req", 32'(data_req), 32'd0);
        chk("flreq idle stall_req", 32'(stall_req), 32'd0);

        // Flush in REQ with addr_ok: drain
        set_op(OP_LW, 32'h3000, 32'h0);
        tick();
        flush        = 1'b1;
        data_addr_ok = 1'b1;
        tick();
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        set_op(6'h00, 32'h0, 32'h0);
        #1;
        chk("flreqok drain stall_req", 32'(stall_req), 32'd1);
        chk("flreqok drain data_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0BAD0;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("flreqok idle stall_req", 32'(stall_req), 32'd0);

        // Flush in WAIT, data_ok two cycles later, then a clean LW
        set_op(OP_LW, 32'h3000, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush        = 1'b1;
        tick();
        flush = 1'b0;
        set_op(6'h00, 32'h0, 32'h0);
        #1;
        chk("flwait drain1 stall_req", 32'(stall_req), 32'd1);
        tick();
        chk("flwait drain2 stall_req", 32'(stall_req), 32'd1);
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0BAD0;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("flwait idle stall_req", 32'(stall_req), 32'd0);
        do_access("lw after drain", OP_LW, 32'h3004, 32'h0, 32'h600DF00D, 32'h0, SIZE_WORD, 1'b0, 32'h600DF00D);

        // Flush in WAIT with data_ok same cycle: straight to IDLE
        set_op(OP_LW, 32'h3000, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush        = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBBBBBBBB;
        tick();
        flush        = 1'b0;
        data_data_ok = 1'b0;
        set_op(6'h00, 32'h0, 32'h0);
        #1;
        chk("flwaitok stall_req", 32'(stall_req), 32'd0);
        chk("flwaitok data_req", 32'(data_req), 32'd0);

        // Flush in DONE overrides stall[3]; LW kept with exr_valid so IDLE shows passthrough data
        set_op(OP_LW, 32'h1000, 32'h0);
        stall = 5'b01000;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h13579BDF;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("fldone done data", output_write_data, 32'h13579BDF);
        flush = 1'b1;
        tick();
        flush            = 1'b0;
        input_exr_valid  = 1'b1;
        input_write_data = 32'h11111111;
        #1;
        chk("fldone idle data", output_write_data, 32'h11111111);
        stall = 5'b0;
        set_op(6'h00, 32'h0, 32'h0);
        tick();

        // Zero-wait acknowledgement still passes through WAIT
        set_op(OP_LW, 32'h5000, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hAAAA5555;
        tick();
        data_addr_ok = 1'b0;
        data_rdata   = 32'h0F0F0F0F;
        #1;
        chk("zw wait stall_req", 32'(stall_req), 32'd1);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("zw done data", output_write_data, 32'h0F0F0F0F);
        chk("zw done stall_req", 32'(stall_req), 32'd0);
        set_op(6'h00, 32'h0, 32'h0);
        tick();

        // Reset during WAIT abandons the transaction
        set_op(OP_LW, 32'h4000, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        resetn       = 1'b0;
        #1;
        chk("rstwait in-reset stall_req", 32'(stall_req), 32'd0);
        tick();
        resetn = 1'b1;
        set_op(6'h00, 32'h0, 32'h0);
        #1;
        chk("rstwait data_req", 32'(data_req), 32'd0);
        chk("rstwait stall_req", 32'(stall_req), 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'hEEEEEEEE;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("rstwait late ok stall_req", 32'(stall_req), 32'd0);
        do_access("lw after rst", OP_LW, 32'h4000, 32'h0, 32'h11223344, 32'h0, SIZE_WORD, 1'b0, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
